// File: rtl/tmds_decoder_if.sv
// Symbol input and decoded output bundle for one TMDS receive channel.
// The slave modport faces the decoder; the master modport faces the deserializer/sink side.
interface tmds_decoder_if;
  logic [9:0] i_symbol;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_valid;
  logic       o_locked;
  logic       o_bitslip;
  logic       o_err;

  modport master (
    output i_symbol,
    input  o_data, o_ctrl, o_de, o_valid, o_locked, o_bitslip, o_err
  );

  modport slave (
    input  i_symbol,
    output o_data, o_ctrl, o_de, o_valid, o_locked, o_bitslip, o_err
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: symbol-boundary alignment via bit slips, 2-stage decode, lock tracking.
// Define TMDS_DISPARITY_CHECK_EN to add running-disparity checking on o_err.
module tmds_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 4
) (
  input logic           i_pixclk,
  input logic           i_reset,
  tmds_decoder_if.slave bus
);
  localparam int RUN_W = $clog2(CTRL_RUN) + 1;
  localparam int WIN_W = $clog2(SEARCH_WINDOW) + 1;
  localparam int SET_W = $clog2(SLIP_SETTLE) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE);

  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} state_t;
  state_t state, state_nxt;

  logic [9:0]       sym_s1;
  logic             is_ctrl_s1, is_ctrl_in;
  logic [1:0]       tok_s1, tok_in;
  logic [7:0]       d_s1, data_dec;
  logic [7:0]       data_q;
  logic [1:0]       ctrl_q;
  logic             de_q;
  logic             valid_d1, valid_q;
  logic             locked, bitslip;
  logic [RUN_W-1:0] run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             run_done, win_expired;

  always_comb begin
    is_ctrl_in = 1'b1;
    tok_in     = 2'b00;
    case (bus.i_symbol)
      10'b1101010100: tok_in = 2'b00;
      10'b0010101011: tok_in = 2'b01;
      10'b0101010100: tok_in = 2'b10;
      10'b1010101011: tok_in = 2'b11;
      default:        is_ctrl_in = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_s1        = sym_s1[9] ? ~sym_s1[7:0] : sym_s1[7:0];
    data_dec    = '0;
    data_dec[0] = d_s1[0];
    for (int i = 1; i < 8; i++)
      data_dec[i] = sym_s1[8] ? (d_s1[i] ^ d_s1[i-1]) : ~(d_s1[i] ^ d_s1[i-1]);
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset) begin
      sym_s1     <= '0;
      is_ctrl_s1 <= 1'b0;
      tok_s1     <= 2'b00;
    end else begin
      sym_s1     <= bus.i_symbol;
      is_ctrl_s1 <= is_ctrl_in;
      tok_s1     <= tok_in;
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      valid_d1 <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_d1 <= locked;
      valid_q  <= valid_d1;
      if (is_ctrl_s1) begin
        de_q   <= 1'b0;
        ctrl_q <= tok_s1;
      end else begin
        de_q   <= 1'b1;
        data_q <= data_dec;
      end
    end
  end

  assign run_done    = (run_cnt == RUN_MAX);
  assign win_expired = (win_cnt == WIN_LAST);

  always_ff @(posedge i_pixclk) begin
    if (!i_reset) state <= SEARCH;
    else          state <= state_nxt;
  end

  // A completed token run always beats window expiry, so lock and slip never coincide.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (run_done)         state_nxt = LOCKED;
        else if (win_expired) state_nxt = SETTLE;
      end
      SETTLE: if (settle_cnt == SET_LAST) state_nxt = SEARCH;
      LOCKED: if (!run_done && win_expired) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked  = (state == LOCKED);
    bitslip = (state == SETTLE) && (settle_cnt == '0);
  end

  // Tokens seen while the deserializer realigns are stale, so the run is held at zero in SETTLE.
  always_ff @(posedge i_pixclk) begin
    if (!i_reset) begin
      run_cnt    <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == SETTLE || (state == LOCKED && state_nxt == SEARCH) || !is_ctrl_s1)
        run_cnt <= '0;
      else if (!run_done)
        run_cnt <= run_cnt + 1'b1;

      if (state != state_nxt || state == SETTLE || run_done)
        win_cnt <= '0;
      else if (!win_expired)
        win_cnt <= win_cnt + 1'b1;

      settle_cnt <= (state == SETTLE && state_nxt == SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_ctrl    = ctrl_q;
  assign bus.o_de      = de_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_locked  = locked;
  assign bus.o_bitslip = bitslip;

`ifdef TMDS_DISPARITY_CHECK_EN
  logic signed [7:0] disp_cnt, disp_nxt, bal;
  logic [3:0]        n1;
  logic              exp_inv, disp_err, err_q;

  // Replay the encoder's disparity rules on the recovered q_m to predict its inversion choice.
  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d_s1[i]};
    bal      = $signed({3'b000, n1, 1'b0}) - 8'sd8;
    exp_inv  = 1'b0;
    disp_nxt = disp_cnt;
    if (disp_cnt == 8'sd0 || bal == 8'sd0) begin
      exp_inv  = ~sym_s1[8];
      disp_nxt = sym_s1[8] ? disp_cnt + bal : disp_cnt - bal;
    end else if ((disp_cnt > 8'sd0 && bal > 8'sd0) || (disp_cnt < 8'sd0 && bal < 8'sd0)) begin
      exp_inv  = 1'b1;
      disp_nxt = disp_cnt + (sym_s1[8] ? 8'sd2 : 8'sd0) - bal;
    end else begin
      exp_inv  = 1'b0;
      disp_nxt = disp_cnt - (sym_s1[8] ? 8'sd0 : 8'sd2) + bal;
    end
    disp_err = (exp_inv != sym_s1[9]) || (disp_nxt > 8'sd10) || (disp_nxt < -8'sd10);
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset) begin
      disp_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      disp_cnt <= is_ctrl_s1 ? 8'sd0 : disp_nxt;
      err_q    <= !is_ctrl_s1 && disp_err && valid_d1;
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed testbench for tmds_decoder: reset, decode, token sweep, disparity, lock loss, alignment.
// Runs with SEARCH_WINDOW=64 so window expiry and bit-slip search finish quickly.
module tb_tmds_decoder;
  localparam int SW  = 64;
  localparam int SET = 4;
  localparam logic [9:0] TOK0   = 10'b1101010100;
  localparam logic [9:0] TOK1   = 10'b0010101011;
  localparam logic [9:0] TOK2   = 10'b0101010100;
  localparam logic [9:0] TOK3   = 10'b1010101011;
  localparam logic [9:0] DATA55 = 10'b0100110011;

  logic i_pixclk = 1'b0;
  logic i_reset  = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;
  logic sawBoth = 1'b0;

  tmds_decoder_if bus();

  tmds_decoder #(.CTRL_RUN(8), .SEARCH_WINDOW(SW), .SLIP_SETTLE(SET)) dut (
    .i_pixclk(i_pixclk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_pixclk = ~i_pixclk;

  always @(negedge i_pixclk)
    if (bus.o_bitslip === 1'b1 && bus.o_locked === 1'b1) sawBoth = 1'b1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [9:0] sym);
    bus.i_symbol = sym;
    @(posedge i_pixclk);
    #1;
  endtask

  function automatic logic [9:0] rotSym(input logic [9:0] s, input int k);
    logic [19:0] t;
    t = {s, s} >> k;
    return t[9:0];
  endfunction

  logic [9:0] decSym [5];
  logic [7:0] decExp [5];

  initial begin
    int n, offset, lastSlip, slips;
    logic quietBad;
    int expErr;

    decSym[0] = 10'b0100000000; decExp[0] = 8'h00;
    decSym[1] = 10'b1011111111; decExp[1] = 8'hFE;
    decSym[2] = 10'b0111111111; decExp[2] = 8'h01;
    decSym[3] = 10'b1000000000; decExp[3] = 8'hFF;
    decSym[4] = DATA55;         decExp[4] = 8'h55;

    // Reset held for three edges while tokens are present
    i_reset = 1'b0;
    bus.i_symbol = TOK0;
    repeat (3) applyStimulus(TOK0);
    checkOutput("rstData",   int'(bus.o_data), 0);
    checkOutput("rstCtrl",   int'(bus.o_ctrl), 0);
    checkOutput("rstDe",     int'(bus.o_de), 0);
    checkOutput("rstValid",  int'(bus.o_valid), 0);
    checkOutput("rstLocked", int'(bus.o_locked), 0);
    checkOutput("rstSlip",   int'(bus.o_bitslip), 0);
    checkOutput("rstErr",    int'(bus.o_err), 0);

    i_reset = 1'b1;
    repeat (7) applyStimulus(TOK0);
    checkOutput("earlyLock", int'(bus.o_locked), 0);
    n = 0;
    while (bus.o_locked !== 1'b1 && n < 20) begin
      applyStimulus(TOK0);
      n++;
    end
    checkOutput("lockAcq", int'(bus.o_locked), 1);
    checkOutput("validLag0", int'(bus.o_valid), 0);
    applyStimulus(TOK0);
    applyStimulus(TOK0);
    checkOutput("validLag2", int'(bus.o_valid), 1);
    checkOutput("lockDe", int'(bus.o_de), 0);
    checkOutput("lockCtrl", int'(bus.o_ctrl), 0);

    // Data decode, each vector followed by a filler token
    for (int i = 0; i < 5; i++) begin
      applyStimulus(decSym[i]);
      checkOutput("decLatency", int'(bus.o_de), 0);
      applyStimulus(TOK0);
      checkOutput("decDe", int'(bus.o_de), 1);
      checkOutput("decData", int'(bus.o_data), int'(decExp[i]));
      checkOutput("decErr", int'(bus.o_err), 0);
      checkOutput("decValid", int'(bus.o_valid), 1);
    end

    // Token sweep with hold behaviour of o_ctrl and o_data
    repeat (10) applyStimulus(TOK0);
    applyStimulus(TOK1);
    applyStimulus(TOK2);
    checkOutput("ctrl01", int'(bus.o_ctrl), 1);
    checkOutput("ctrl01De", int'(bus.o_de), 0);
    applyStimulus(TOK3);
    checkOutput("ctrl10", int'(bus.o_ctrl), 2);
    applyStimulus(DATA55);
    checkOutput("ctrl11", int'(bus.o_ctrl), 3);
    applyStimulus(TOK0);
    checkOutput("ctrlHoldDe", int'(bus.o_de), 1);
    checkOutput("ctrlHold", int'(bus.o_ctrl), 3);
    applyStimulus(TOK0);
    checkOutput("dataHoldDe", int'(bus.o_de), 0);
    checkOutput("dataHoldCtrl", int'(bus.o_ctrl), 0);
    checkOutput("dataHold", int'(bus.o_data), 8'h55);

    // Data symbol whose q[9] contradicts the inversion rule at zero disparity
    repeat (10) applyStimulus(TOK0);
`ifdef TMDS_DISPARITY_CHECK_EN
    expErr = 1;
`else
    expErr = 0;
`endif
    applyStimulus(10'b1100110011);
    applyStimulus(TOK0);
    checkOutput("dispDe", int'(bus.o_de), 1);
    checkOutput("dispData", int'(bus.o_data), 8'h54);
    checkOutput("dispErr", int'(bus.o_err), expErr);
    applyStimulus(TOK0);
    checkOutput("dispErrPulse", int'(bus.o_err), 0);

    // Lock loss on a data-only stream
    repeat (10) applyStimulus(TOK0);
    n = 0;
    while (bus.o_locked === 1'b1 && n < 100) begin
      applyStimulus(DATA55);
      n++;
    end
    checkOutput("lockLost", int'(bus.o_locked), 0);
    checkOutput("lossLatency", int'(n >= SW && n <= SW + 4), 1);
    checkOutput("noSlipAtDrop", int'(bus.o_bitslip), 0);
    applyStimulus(DATA55);
    checkOutput("noSlipAfterDrop", int'(bus.o_bitslip), 0);
    n = 0;
    while (bus.o_locked !== 1'b1 && n < 20) begin
      applyStimulus(TOK0);
      n++;
    end
    checkOutput("relock", int'(bus.o_locked), 1);

    // Alignment search on a stream rotated by three bits
    offset = 3;
    i_reset = 1'b0;
    repeat (2) applyStimulus(rotSym(TOK0, offset));
    i_reset = 1'b1;
    slips = 0;
    lastSlip = -100;
    quietBad = 1'b0;
    n = 0;
    while (bus.o_locked !== 1'b1 && n < 600) begin
      applyStimulus(rotSym(TOK0, offset));
      n++;
      if (bus.o_bitslip === 1'b1) begin
        if (n - lastSlip <= SET) quietBad = 1'b1;
        lastSlip = n;
        slips++;
        if (offset > 0) offset--;
      end
    end
    if (n - lastSlip <= SET) quietBad = 1'b1;
    checkOutput("alignLock", int'(bus.o_locked), 1);
    checkOutput("slipCount", slips, 3);
    checkOutput("slipQuiet", int'(quietBad), 0);
    checkOutput("slipLockExcl", int'(sawBoth), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
